// File: rtl/fft_frame_source.sv
// fft_frame_source: buffers a sample stream and emits overlapping FFT_LEN-sample frames every HOP samples
module fft_frame_source #(
  parameter int bit_length = 32,
  parameter int FFT_LEN = 16,
  parameter int HOP = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [bit_length-1:0] sample_in,
  output logic                  sample_ready,
  output logic                  enable_out,
  output logic [bit_length-1:0] data_out_re,
  output logic [bit_length-1:0] data_out_im,
  output logic                  frame_start
);
  localparam int AW = $clog2(FFT_LEN);
  localparam logic [1:0] FILL = 2'd0, WAIT = 2'd1, BURST = 2'd2;
  logic [1:0] state;
  logic [AW-1:0] wp, cnt;
  logic [AW:0] k;
  logic [bit_length-1:0] mem [FFT_LEN];
  logic accept, last;
  assign accept = sample_valid && sample_ready;
  assign last = cnt == ((state == FILL) ? AW'(FFT_LEN - 1) : AW'(HOP - 1));
  assign data_out_im = '0;
  // Window storage survives reset; only pointers and state are cleared
  always_ff @(posedge clk) begin
    if (accept) mem[wp] <= sample_in;
  end
  // Fill/wait counting and burst sequencing; k == FFT_LEN is the one-cycle tail that keeps ready low
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      wp <= '0;
      cnt <= '0;
      k <= '0;
      sample_ready <= 1'b0;
      enable_out <= 1'b0;
      frame_start <= 1'b0;
      data_out_re <= '0;
    end else begin
      enable_out <= 1'b0;
      frame_start <= 1'b0;
      data_out_re <= '0;
      if (state == BURST) begin
        if (k == (AW+1)'(FFT_LEN)) begin
          state <= WAIT;
          sample_ready <= 1'b1;
        end else begin
          enable_out <= 1'b1;
          frame_start <= k == '0;
          data_out_re <= mem[wp + k[AW-1:0]];
          k <= k + 1'b1;
        end
      end else begin
        sample_ready <= 1'b1;
        if (accept) begin
          wp <= wp + 1'b1;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            state <= BURST;
            k <= '0;
            sample_ready <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: doc/fft_frame_source.md
# fft_frame_source

Streaming front end for the noise-cancellation FFT chain. It accepts one real audio sample at a time over a valid/ready handshake and stores the samples in a circular window buffer. Once per hop it emits the most recent FFT_LEN samples as one contiguous burst in the chain's enable/real/imag stream format, so the output connects directly to the FFT stage's data input. It is the producer side of that stream interface: it turns an unframed sample flow into the framed bursts the FFT consumes.

## Interface
Parameters:
- `bit_length`, 32, width of the sample and of each output real/imag word.
- `FFT_LEN`, 16, frame length. Must be a power of two, at least 4.
- `HOP`, 8, number of new samples between consecutive frames. Must satisfy 1 ≤ HOP ≤ FFT_LEN.

Ports:
- `clk`  in  1  the single clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `sample_valid`  in  1  `sample_in` holds a valid sample.
- `sample_in`  in  bit_length  signed audio sample.
- `sample_ready`  out  1  the block can accept a sample this cycle.
- `enable_out`  out  1  a valid frame beat is on the data outputs.
- `data_out_re`  out  bit_length  beat real part, equal to the stored sample.
- `data_out_im`  out  bit_length  beat imaginary part, always 0.
- `frame_start`  out  1  high only on the first beat of each frame.

## Operation
- A sample is accepted on an edge where `sample_valid` && `sample_ready`. It is written to `buf[wp]` and `wp` increments modulo FFT_LEN.
- State FILL is entered after reset. It accepts samples until FFT_LEN have been accepted. The FFT_LEN-th accepted sample moves the block to BURST.
- State WAIT accepts samples until HOP new samples have arrived since the last frame. The HOP-th sample moves the block to BURST.
- In state BURST:
  - `sample_ready` is 0.
  - The block emits FFT_LEN beats on consecutive cycles, oldest sample first. Beat k carries `buf[(wp + k) mod FFT_LEN]`, where `wp` is the value after the completing write.
  - After the last beat the block moves to WAIT with the hop count cleared.
- Frame window: the FFT_LEN most recently accepted samples. Consecutive frames overlap by FFT_LEN − HOP samples.
- Data is passed through unchanged. There is no scaling, windowing or sign change. `data_out_im` is constant 0.
- An upstream sample held on `sample_valid` while `sample_ready` is 0 is neither lost nor duplicated. It is accepted on the first cycle `sample_ready` returns to 1.
- Buffer contents are not cleared by reset. Pointers, counters and state are cleared.

## Timing
- During reset and on the cycle after the reset edge:
  - `enable_out`, `frame_start`, `data_out_re` and `data_out_im` are 0.
  - `sample_ready` is 0 while `reset` is high. It goes to 1 on the first cycle after `reset` deasserts, in state FILL.
- Latency: the completing sample is accepted at edge E.
  - `enable_out` is high from edge E+1 through edge E+FFT_LEN, i.e. FFT_LEN cycles with no gaps.
  - `frame_start` is high only in the cycle after edge E+1.
  - `enable_out` returns to 0 at edge E+FFT_LEN+1.
- `sample_ready` goes to 0 at edge E and back to 1 at edge E+FFT_LEN+1, so it is low for FFT_LEN+1 cycles.
- All outputs are registered. Between bursts, `data_out_re` and `data_out_im` are 0.
- Sparse input (valid not asserted every cycle) is allowed. Burst timing is measured only from the completing acceptance edge.
- HOP = FFT_LEN gives non-overlapping frames.
- Reset asserted mid-burst:
  - `enable_out` is 0 from the reset edge. The partial frame is abandoned and is not resumed.
  - After reset the block is in FILL and needs FFT_LEN new samples before the next frame.

## Test plan
- Defaults (FFT_LEN=16, HOP=8). Release reset, then drive samples 1..16 with valid every cycle.
  - Required: one 16-beat burst with `data_out_re` 1..16 in order, `data_out_im` 0, `frame_start` only on the beat carrying 1.
  - Required: `sample_ready` low for 17 cycles starting at the acceptance edge of sample 16.
- Continue with samples 17..24.
  - Required: a second burst with `data_out_re` 9..24.
  - Required: no burst occurs after only 7 of those samples.
- Hold `sample_valid`=1 with value 25 throughout the second burst.
  - Required: 25 is accepted exactly once, on the cycle `sample_ready` returns to 1.
  - Required: the following frame after 32 is reached contains 17..32.
- HOP=16 instance, samples 1..32.
  - Required: frames 1..16 and 17..32, with no overlap and no extra frames.
- Assert reset during beat 5 of a burst.
  - Required: `enable_out` is 0 from the reset edge.
  - Required: after reset, 15 samples produce no frame; the 16th triggers a frame containing exactly those 16 samples.
- Samples 32'hFFFF_FFFF and 32'h8000_0000 presented with valid every 3rd cycle.
  - Required: values are reproduced bit-exact.
  - Required: burst starts at E+1 relative to the completing acceptance edge.
